// File: rtl/niosballe_pio_pkg.sv
// Shared definitions for the Nios II PIO pair: word address map, edge encodings, edge-detect helper.
package niosballe_pio_pkg;

   localparam int unsigned BUS_W  = 32;
   localparam int unsigned ADDR_W = 2;

   localparam logic [ADDR_W-1:0] ADDR_DATA    = 2'd0;
   localparam logic [ADDR_W-1:0] ADDR_MASK    = 2'd2;
   localparam logic [ADDR_W-1:0] ADDR_EDGECAP = 2'd3;

   typedef enum logic [1:0] {
      EDGE_RISE = 2'd0,
      EDGE_FALL = 2'd1,
      EDGE_ANY  = 2'd2
   } edge_type_e;

   function automatic logic [BUS_W-1:0] edge_detect(input logic [BUS_W-1:0] cur,
                                                    input logic [BUS_W-1:0] prv,
                                                    input edge_type_e       et);
      case (et)
         EDGE_RISE: return cur & ~prv;
         EDGE_FALL: return ~cur & prv;
         default:   return cur ^ prv;
      endcase
   endfunction

endpackage

// File: rtl/niosballe_in_pio_if.sv
// Avalon-MM slave bus of the input PIO, including its level interrupt.
interface niosballe_in_pio_if;
   import niosballe_pio_pkg::*;

   logic [ADDR_W-1:0] address;
   logic              chipselect;
   logic              read_n;
   logic              write_n;
   logic [BUS_W-1:0]  writedata;
   logic [BUS_W-1:0]  readdata;
   logic              irq;

   modport master (output address, chipselect, read_n, write_n, writedata,
                   input  readdata, irq);
   modport slave  (input  address, chipselect, read_n, write_n, writedata,
                   output readdata, irq);
endinterface

// File: rtl/niosballe_pio_debounce.sv
// One-bit debouncer: output follows the input only after it has differed for DEBOUNCE_CYCLES clocks.
module niosballe_pio_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic stable
);
   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CNT_W-1:0] cnt;

   // Any return to the current value restarts the count; the counter never passes CNT_LAST.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt    <= '0;
         stable <= 1'b0;
      end else if (raw == stable) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         stable <= raw;
         cnt    <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end
endmodule

// File: rtl/niosballe_in_pio.sv
// Avalon-MM input PIO with sticky edge capture and masked level irq.
// Optional input debouncing when NIOSBALLE_IN_PIO_DEBOUNCE_EN is defined.
module niosballe_in_pio
   import niosballe_pio_pkg::*;
#(
   parameter int unsigned WIDTH           = 4,
   parameter int unsigned EDGE_TYPE       = 0,
   parameter logic [31:0] RESET_MASK      = 32'h0,
   parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [WIDTH-1:0]    in_port,
   niosballe_in_pio_if.slave   bus
);
   localparam edge_type_e ETYPE = edge_type_e'(2'(EDGE_TYPE));

   logic [WIDTH-1:0] sync1, sync2, sync_q, prev, edge_q;
   logic [WIDTH-1:0] edge_capture, irq_mask;
   logic [WIDTH-1:0] cap_nxt, mask_nxt, clr_c;
   logic [BUS_W-1:0] edge_all;
   logic             wr_c, rd_c;
   logic             unused_bits;

   if (WIDTH < 1 || WIDTH > 32 || DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
      $error("niosballe_in_pio: unsupported WIDTH or DEBOUNCE_CYCLES");
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= in_port;
         sync2 <= sync1;
      end
   end

`ifdef NIOSBALLE_IN_PIO_DEBOUNCE_EN
   for (genvar i = 0; i < int'(WIDTH); i++) begin : g_db
      niosballe_pio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk    (clk),
         .reset  (reset),
         .raw    (sync2[i]),
         .stable (sync_q[i])
      );
   end
`else
   assign sync_q = sync2;
`endif

   assign edge_all    = edge_detect(BUS_W'(sync_q), BUS_W'(prev), ETYPE);
   assign wr_c        = bus.chipselect && !bus.write_n;
   assign rd_c        = bus.chipselect && !bus.read_n;
   assign unused_bits = &{1'b0, bus.writedata, edge_all};

   // Next-state mask and capture; a fresh edge overrides a same-cycle W1C.
   always_comb begin
      mask_nxt = irq_mask;
      clr_c    = '0;
      if (wr_c && bus.address == ADDR_MASK)    mask_nxt = bus.writedata[WIDTH-1:0];
      if (wr_c && bus.address == ADDR_EDGECAP) clr_c    = bus.writedata[WIDTH-1:0];
      cap_nxt = (edge_capture & ~clr_c) | edge_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prev         <= '0;
         edge_q       <= '0;
         edge_capture <= '0;
         irq_mask     <= RESET_MASK[WIDTH-1:0];
         bus.irq      <= 1'b0;
         bus.readdata <= '0;
      end else begin
         prev         <= sync_q;
         edge_q       <= edge_all[WIDTH-1:0];
         edge_capture <= cap_nxt;
         irq_mask     <= mask_nxt;
         bus.irq      <= |(cap_nxt & mask_nxt);
         if (rd_c) begin
            case (bus.address)
               ADDR_DATA:    bus.readdata <= BUS_W'(sync_q);
               ADDR_MASK:    bus.readdata <= BUS_W'(irq_mask);
               ADDR_EDGECAP: bus.readdata <= BUS_W'(edge_capture);
               default:      bus.readdata <= '0;
            endcase
         end
      end
   end
endmodule
